rr_sel_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8:1 byte-select datapath.
- Eight requesters each present a request and a data byte. The block grants one requester at a time for a bounded burst and drives the 3-bit select.
- It captures the selected byte into a registered output stage with a valid/ready handshake toward the downstream consumer.
- It replaces free-running, unregistered select control with fair, backpressure-aware scheduling.

---
 rtl/rr_sel_if.sv | 29 ++
 rtl/rr_sel_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_sel_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_sel_if.sv
// Handshake bundle between the round-robin arbiter, its eight requesters and
// the downstream byte consumer.
interface rr_sel_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic [N-1:0]   ack;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready;

  // arbiter side: owns grant, select, beat acknowledge and the output stage
  modport master (
    input  req, din, dout_ready,
    output gnt, sel, ack, dout, dout_valid
  );

  // requesters and consumer side
  modport slave (
    output req, din, dout_ready,
    input  gnt, sel, ack, dout, dout_valid
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter for the shared 8:1 byte-select datapath. Grants one
// requester at a time for up to BURST beats and registers the selected byte
// into a valid/ready output stage.
//
// state | meaning
// IDLE  | no grant; scan req from ptr and pick the next requester
// GRANT | gnt/sel point at one requester; beats move while the slot is free
module rr_sel_arbiter #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_sel_if.master bus
);
  localparam int SW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic [N-1:0]  gnt, gnt_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [W-1:0]  dout, dout_nxt;
  logic          dout_valid, dout_valid_nxt;

  logic          slot_free;
  logic          beat;
  logic          found;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic [W-1:0]  din_sel;

  // the output register can accept a new byte if empty or being drained now
  assign slot_free = !dout_valid | bus.dout_ready;
  assign beat      = (state == GRANT) & bus.req[sel] & slot_free;
  assign bus.ack   = beat ? (N'(1) << sel) : '0;

  assign bus.gnt        = gnt;
  assign bus.sel        = sel;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;

  // byte mux on the registered select
  always_comb begin
    din_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) din_sel = bus.din[i*W +: W];
    end
  end

  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + SW'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // next-state, grant bookkeeping and output-stage update
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    sel_nxt        = sel;
    gnt_nxt        = gnt;
    cnt_nxt        = cnt;
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;

    // a waiting byte drains whenever no new beat replaces it
    if (!beat && bus.dout_ready) dout_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << pick;
          sel_nxt   = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          dout_nxt       = din_sel;
          dout_valid_nxt = 1'b1;
          cnt_nxt        = cnt + 4'd1;
        end
        // req is only checked here, so a beat already captured is never lost
        if (!bus.req[sel] || (beat && cnt_nxt == 4'(BURST))) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = sel + SW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      sel        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      sel        <= sel_nxt;
      gnt        <= gnt_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
    end
  end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: requesters are byte queues that advance on ack,
// the consumer takes bytes on valid&ready, and a transaction-level model
// predicts grant order and byte stream from the round-robin/burst rules.
module tb_rr_sel_arbiter;
  localparam int N = 8;
  localparam int W = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_sel_if #(.N(N), .W(W)) bus ();
  rr_sel_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   q      [N][$];
  logic [7:0]   init_q [N][$];
  int           exp_grants[$], got_grants[$], gaps[$];
  logic [7:0]   exp_bytes[$], got_bytes[$];
  logic [N-1:0] tr_gnt[$], tr_ack[$];
  logic [2:0]   tr_sel[$];
  logic [7:0]   tr_dout[$];
  logic         tr_dv[$];
  logic         rdy_pat[$];
  int           bad_inv;
  bit           timed_out;

  logic [N-1:0] s_gnt, s_ack;
  logic [2:0]   s_sel;
  logic [7:0]   s_dout;
  logic         s_dv;

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load();
    for (int i = 0; i < N; i++) init_q[i] = q[i];
  endtask

  // reference: round-robin over nonempty queues, at most BURST bytes per grant
  task automatic build_model();
    int rem[N];
    int pos[N];
    int p, k, take;
    exp_grants.delete();
    exp_bytes.delete();
    for (int i = 0; i < N; i++) begin rem[i] = init_q[i].size(); pos[i] = 0; end
    p = 0;
    forever begin
      k = -1;
      for (int j = 0; j < N; j++) if (k < 0 && rem[(p + j) % N] > 0) k = (p + j) % N;
      if (k < 0) break;
      exp_grants.push_back(k);
      take = (rem[k] < BURST) ? rem[k] : BURST;
      for (int b = 0; b < take; b++) begin exp_bytes.push_back(init_q[k][pos[k]]); pos[k]++; end
      rem[k] -= take;
      p = (k + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    bus.req = '0;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle: drive requesters/consumer mid-cycle, snapshot outputs, advance queues
  task automatic step(input logic rdy);
    @(negedge clk);
    bus.dout_ready = rdy;
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (q[i].size() > 0);
      bus.din[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
    end
    #1;
    s_gnt = bus.gnt; s_ack = bus.ack; s_sel = bus.sel; s_dout = bus.dout; s_dv = bus.dout_valid;
    for (int i = 0; i < N; i++) begin
      if (s_ack[i]) begin
        if (q[i].size() > 0) void'(q[i].pop_front());
        else bad_inv++;
      end
    end
    if (s_dv && rdy) got_bytes.push_back(s_dout);
    tr_gnt.push_back(s_gnt); tr_ack.push_back(s_ack); tr_sel.push_back(s_sel);
    tr_dout.push_back(s_dout); tr_dv.push_back(s_dv);
  endtask

  task automatic run(input int max_cyc, input bit rand_rdy);
    logic [N-1:0] prev;
    logic [7:0]   pdout;
    logic         pdv, prdy, r;
    int           gap;
    bit           first;
    got_grants.delete(); got_bytes.delete(); gaps.delete();
    tr_gnt.delete(); tr_ack.delete(); tr_sel.delete(); tr_dout.delete(); tr_dv.delete();
    bad_inv = 0; timed_out = 1'b1;
    prev = '0; gap = 0; first = 1'b0; pdv = 1'b0; prdy = 1'b1; pdout = '0;
    for (int c = 0; c < max_cyc; c++) begin
      if (rand_rdy) r = ($urandom_range(0, 3) != 0);
      else r = (c < rdy_pat.size()) ? rdy_pat[c] : 1'b1;
      step(r);
      if (!$onehot0(s_gnt) || !$onehot0(s_ack) || ((s_ack & ~s_gnt) != '0)) bad_inv++;
      if (s_gnt != '0 && s_gnt != (N'(1) << s_sel)) bad_inv++;
      if (prev != '0 && s_gnt != '0 && prev != s_gnt) bad_inv++;
      if (pdv && !prdy && (!s_dv || s_dout !== pdout)) bad_inv++;
      if (s_gnt != '0 && prev == '0) begin
        got_grants.push_back(int'(s_sel));
        if (first) gaps.push_back(gap);
        first = 1'b1;
        gap = 0;
      end
      if (s_gnt == '0) gap++;
      prev = s_gnt; pdv = s_dv; pdout = s_dout; prdy = r;
      if (all_empty() && s_gnt == '0 && !s_dv) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = N'($urandom);
    bus.din = {$urandom, $urandom};
    bus.dout_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %h want 0", bus.gnt); end
    vectors++; if (bus.ack !== '0) begin miscompares++; $display("FAIL reset_ack: got %h want 0", bus.ack); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %b want 0", bus.dout_valid); end
    bus.req = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (bus.gnt !== '0 || bus.ack !== '0 || bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.sel !== '0) begin
        miscompares++;
        $display("FAIL idle_hold c%0d: got gnt=%h ack=%h dout=%h dv=%b sel=%0d want all 0",
                 c, bus.gnt, bus.ack, bus.dout, bus.dout_valid, bus.sel);
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [7:0] e_gnt [10] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
    logic       e_dv  [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [7:0] e_do  [10] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00};
    do_reset();
    for (int b = 0; b < 6; b++) q[3].push_back(8'(8'h10 + b));
    rdy_pat.delete();
    run(60, 1'b0);
    vectors++; if (timed_out || tr_gnt.size() != 10) begin miscompares++; $display("FAIL burst_len: got %0d cycles (timeout=%b) want 10", tr_gnt.size(), timed_out); end
    for (int c = 0; c < 10 && c < tr_gnt.size(); c++) begin
      vectors++;
      if (tr_gnt[c] !== e_gnt[c] || tr_dv[c] !== e_dv[c] || (e_dv[c] && tr_dout[c] !== e_do[c]) || (e_gnt[c] != 0 && tr_sel[c] !== 3'd3)) begin
        miscompares++;
        $display("FAIL burst_c%0d: got gnt=%h dv=%b dout=%h sel=%0d want gnt=%h dv=%b dout=%h sel=3",
                 c, tr_gnt[c], tr_dv[c], tr_dout[c], tr_sel[c], e_gnt[c], e_dv[c], e_do[c]);
      end
    end
    if (tr_ack.size() > 1) begin
      vectors++; if (tr_ack[1] !== 8'h08) begin miscompares++; $display("FAIL burst_first_ack: got %h want 08", tr_ack[1]); end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < ((i == 0) ? 2 * BURST : BURST); b++) q[i].push_back(8'(8'hA0 + i));
    load(); build_model(); rdy_pat.delete();
    run(200, 1'b0);
    vectors++; if (timed_out || bad_inv != 0) begin miscompares++; $display("FAIL rot_status: got timeout=%b bad_inv=%0d want 0/0", timed_out, bad_inv); end
    vectors++; if (got_grants.size() != exp_grants.size()) begin miscompares++; $display("FAIL rot_ngrants: got %0d want %0d", got_grants.size(), exp_grants.size()); end
    for (int k = 0; k < exp_grants.size() && k < got_grants.size(); k++) begin
      vectors++; if (got_grants[k] != exp_grants[k]) begin miscompares++; $display("FAIL rot_grant%0d: got %0d want %0d", k, got_grants[k], exp_grants[k]); end
    end
    vectors++; if (got_bytes.size() != exp_bytes.size()) begin miscompares++; $display("FAIL rot_nbytes: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++) begin
      vectors++; if (got_bytes[k] !== exp_bytes[k]) begin miscompares++; $display("FAIL rot_byte%0d: got %h want %h", k, got_bytes[k], exp_bytes[k]); end
    end
    foreach (gaps[k]) begin
      vectors++; if (gaps[k] != 1) begin miscompares++; $display("FAIL rot_gap%0d: got %0d want 1", k, gaps[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int b = 0; b < 4; b++) q[5].push_back(8'(8'h50 + b));
    rdy_pat.delete();
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run(60, 1'b0);
    vectors++; if (timed_out || tr_gnt.size() < 9) begin miscompares++; $display("FAIL bp_len: got %0d cycles (timeout=%b) want >=9", tr_gnt.size(), timed_out); end
    else begin
      for (int c = 3; c < 6; c++) begin
        vectors++;
        if (tr_dout[c] !== 8'h51 || tr_dv[c] !== 1'b1 || tr_ack[c] !== '0 || tr_gnt[c] !== 8'h20) begin
          miscompares++;
          $display("FAIL bp_stall_c%0d: got dout=%h dv=%b ack=%h gnt=%h want 51/1/00/20", c, tr_dout[c], tr_dv[c], tr_ack[c], tr_gnt[c]);
        end
      end
      vectors++; if (tr_ack[6] !== 8'h20) begin miscompares++; $display("FAIL bp_release_ack: got %h want 20", tr_ack[6]); end
      vectors++; if (tr_dout[7] !== 8'h52 || tr_dv[7] !== 1'b1) begin miscompares++; $display("FAIL bp_reload: got %h/%b want 52/1", tr_dout[7], tr_dv[7]); end
      vectors++; if (tr_gnt[8] !== '0 || tr_dout[8] !== 8'h53) begin miscompares++; $display("FAIL bp_end: got gnt=%h dout=%h want 00/53", tr_gnt[8], tr_dout[8]); end
    end
    vectors++; if (got_bytes.size() != 4) begin miscompares++; $display("FAIL bp_nbytes: got %0d want 4", got_bytes.size()); end
  endtask

  task automatic test_early_drop();
    do_reset();
    q[2] = '{8'h20, 8'h21};
    q[6] = '{8'h60, 8'h61, 8'h62};
    load(); build_model(); rdy_pat.delete();
    run(60, 1'b0);
    vectors++; if (timed_out || bad_inv != 0) begin miscompares++; $display("FAIL drop_status: got timeout=%b bad_inv=%0d want 0/0", timed_out, bad_inv); end
    vectors++; if (got_grants.size() != 2 || got_grants[0] != 2 || got_grants[1] != 6) begin miscompares++; $display("FAIL drop_grants: got %p want 2,6", got_grants); end
    vectors++; if (gaps.size() != 1 || gaps[0] != 1) begin miscompares++; $display("FAIL drop_gap: got %p want 1", gaps); end
    vectors++; if (got_bytes.size() != exp_bytes.size()) begin miscompares++; $display("FAIL drop_nbytes: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++) begin
      vectors++; if (got_bytes[k] !== exp_bytes[k]) begin miscompares++; $display("FAIL drop_byte%0d: got %h want %h", k, got_bytes[k], exp_bytes[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[6].push_back(8'h66);
    rdy_pat.delete();
    run(30, 1'b0);
    for (int b = 0; b < 4; b++) q[1].push_back(8'(8'h30 + b));
    step(1'b1); step(1'b1); step(1'b0);
    vectors++; if (s_dv !== 1'b1 || s_gnt !== 8'h02) begin miscompares++; $display("FAIL mid_pre: got dv=%b gnt=%h want 1/02", s_dv, s_gnt); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.dout_valid !== 1'b0 || bus.gnt !== '0 || bus.ack !== '0) begin
      miscompares++; $display("FAIL mid_async: got dv=%b gnt=%h ack=%h want 0/00/00", bus.dout_valid, bus.gnt, bus.ack);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q[1] = '{8'h71, 8'h72};
    q[7] = '{8'h77};
    load(); build_model();
    run(60, 1'b0);
    vectors++; if (timed_out || got_grants.size() != exp_grants.size() || got_grants.size() == 0 || got_grants[0] != exp_grants[0]) begin
      miscompares++; $display("FAIL mid_restart: got %p want %p", got_grants, exp_grants);
    end
    vectors++; if (got_bytes != exp_bytes) begin miscompares++; $display("FAIL mid_bytes: got %p want %p", got_bytes, exp_bytes); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int len = $urandom_range(0, 9);
        for (int b = 0; b < len; b++) q[i].push_back(8'($urandom));
      end
      load(); build_model();
      run(3000, 1'b1);
      vectors++; if (timed_out || bad_inv != 0) begin miscompares++; $display("FAIL rnd%0d_status: got timeout=%b bad_inv=%0d want 0/0", it, timed_out, bad_inv); end
      vectors++; if (got_grants != exp_grants) begin miscompares++; $display("FAIL rnd%0d_grants: got %0d grants want %0d", it, got_grants.size(), exp_grants.size()); end
      vectors++; if (got_bytes.size() != exp_bytes.size()) begin miscompares++; $display("FAIL rnd%0d_nbytes: got %0d want %0d", it, got_bytes.size(), exp_bytes.size()); end
      for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++) begin
        vectors++; if (got_bytes[k] !== exp_bytes[k]) begin miscompares++; $display("FAIL rnd%0d_byte%0d: got %h want %h", it, k, got_bytes[k], exp_bytes[k]); end
      end
      foreach (gaps[k]) begin
        vectors++; if (gaps[k] != 1) begin miscompares++; $display("FAIL rnd%0d_gap%0d: got %0d want 1", it, k, gaps[k]); end
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.dout_ready = 1'b1;
    bad_inv = 0;
    test_reset();
    test_burst_limit();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end
endmodule
